// File: rtl/bsg_tag_serial_tx.sv
// rtl/bsg_tag_serial_tx.sv - bsg_tag serial transmitter: packets and master reset onto the tag data/enable pads.
// Optional zero-length data packet rejection: define BSG_TAG_SERIAL_TX_LEN_CHECK_EN.
module bsg_tag_serial_tx #(
    parameter int els_p        = 32,
    parameter int lg_width_p   = 5,
    parameter int reset_ones_p = 64,
    parameter int gap_p        = 2,
    localparam int id_w        = (els_p <= 1) ? 1 : $clog2(els_p),
    localparam int max_w       = (1 << lg_width_p) - 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  v_i,
    output logic                  ready_and_o,
    input  logic                  master_reset_i,
    input  logic [id_w-1:0]       nodeid_i,
    input  logic                  data_not_reset_i,
    input  logic [lg_width_p-1:0] len_i,
    input  logic [max_w-1:0]      payload_i,
    output logic                  tag_data_o,
    output logic                  tag_en_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);
    localparam int c_rst = $clog2(reset_ones_p + 1);
    localparam int c_gap = $clog2(gap_p + 1);
    localparam int c_a   = (c_rst > lg_width_p) ? c_rst : lg_width_p;
    localparam int c_b   = (c_a > id_w) ? c_a : id_w;
    localparam int cnt_w = (c_b > c_gap) ? c_b : c_gap;

    typedef enum logic [2:0] {IDLE, MRST, START, LEN, DNR, ID, PAY, GAP} state_e;

    state_e                  state_r, state_n;
    logic [cnt_w-1:0]        cnt_r, cnt_n;
    logic [lg_width_p-1:0]   len_r, len_n, len_sh_r, len_sh_n;
    logic                    dnr_r, dnr_n;
    logic [id_w-1:0]         id_sh_r, id_sh_n;
    logic [max_w-1:0]        pay_sh_r, pay_sh_n;
    logic                    err_r, err_n;
    logic                    hs;
    logic                    reject;

    assign ready_and_o = (state_r == IDLE) && !reset_i;
    assign hs          = v_i && ready_and_o;
    assign busy_o      = (state_r != IDLE);
    assign tag_en_o    = (state_r != IDLE);
    assign done_o      = (state_r == GAP) && (cnt_r == '0);
    assign error_o     = err_r;

`ifdef BSG_TAG_SERIAL_TX_LEN_CHECK_EN
    assign reject = !master_reset_i && data_not_reset_i && (len_i == '0);
`else
    assign reject = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            len_r    <= '0;
            len_sh_r <= '0;
            dnr_r    <= 1'b0;
            id_sh_r  <= '0;
            pay_sh_r <= '0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_n;
            cnt_r    <= cnt_n;
            len_r    <= len_n;
            len_sh_r <= len_sh_n;
            dnr_r    <= dnr_n;
            id_sh_r  <= id_sh_n;
            pay_sh_r <= pay_sh_n;
            err_r    <= err_n;
        end
    end

    // cnt_r holds the number of bits left in the current field minus one.
    always_comb begin
        state_n  = state_r;
        cnt_n    = cnt_r;
        len_n    = len_r;
        len_sh_n = len_sh_r;
        dnr_n    = dnr_r;
        id_sh_n  = id_sh_r;
        pay_sh_n = pay_sh_r;
        err_n    = err_r;
        case (state_r)
            IDLE: begin
                if (hs) begin
                    if (master_reset_i) begin
                        state_n = MRST;
                        cnt_n   = cnt_w'(reset_ones_p - 1);
                    end else if (reject) begin
                        err_n = 1'b1;
                    end else begin
                        state_n  = START;
                        cnt_n    = '0;
                        len_n    = len_i;
                        len_sh_n = len_i;
                        dnr_n    = data_not_reset_i;
                        id_sh_n  = nodeid_i;
                        pay_sh_n = payload_i;
                    end
                end
            end
            MRST: begin
                if (cnt_r == '0) begin
                    state_n = GAP;
                    cnt_n   = cnt_w'(gap_p - 1);
                end else begin
                    cnt_n = cnt_r - 1'b1;
                end
            end
            START: begin
                state_n = LEN;
                cnt_n   = cnt_w'(lg_width_p - 1);
            end
            LEN: begin
                len_sh_n = len_sh_r >> 1;
                if (cnt_r == '0) begin
                    state_n = DNR;
                end else begin
                    cnt_n = cnt_r - 1'b1;
                end
            end
            DNR: begin
                state_n = ID;
                cnt_n   = cnt_w'(id_w - 1);
            end
            ID: begin
                id_sh_n = id_sh_r >> 1;
                if (cnt_r != '0) begin
                    cnt_n = cnt_r - 1'b1;
                end else if (len_r == '0) begin
                    state_n = GAP;
                    cnt_n   = cnt_w'(gap_p - 1);
                end else begin
                    state_n = PAY;
                    cnt_n   = cnt_w'(len_r) - cnt_w'(1);
                end
            end
            PAY: begin
                pay_sh_n = pay_sh_r >> 1;
                if (cnt_r == '0) begin
                    state_n = GAP;
                    cnt_n   = cnt_w'(gap_p - 1);
                end else begin
                    cnt_n = cnt_r - 1'b1;
                end
            end
            GAP: begin
                if (cnt_r == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_r - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        tag_data_o = 1'b0;
        case (state_r)
            MRST:    tag_data_o = 1'b1;
            START:   tag_data_o = 1'b1;
            LEN:     tag_data_o = len_sh_r[0];
            DNR:     tag_data_o = dnr_r;
            ID:      tag_data_o = id_sh_r[0];
            PAY:     tag_data_o = pay_sh_r[0];
            default: tag_data_o = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_bsg_tag_serial_tx.sv
// tb/tb_bsg_tag_serial_tx.sv - directed scoreboard bench for bsg_tag_serial_tx.
module tb_bsg_tag_serial_tx;
    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        v_i = 1'b0;
    logic        ready_and_o;
    logic        master_reset_i = 1'b0;
    logic [4:0]  nodeid_i = '0;
    logic        data_not_reset_i = 1'b0;
    logic [4:0]  len_i = '0;
    logic [30:0] payload_i = '0;
    logic        tag_data_o, tag_en_o, busy_o, done_o, error_o;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    logic [2:0] exp_q[$];   // {done, en, data} per cycle
    logic       rx_q[$];

    bsg_tag_serial_tx dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_and_o(ready_and_o),
        .master_reset_i(master_reset_i), .nodeid_i(nodeid_i),
        .data_not_reset_i(data_not_reset_i), .len_i(len_i), .payload_i(payload_i),
        .tag_data_o(tag_data_o), .tag_en_o(tag_en_o), .busy_o(busy_o),
        .done_o(done_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_bits(input logic [31:0] val, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 1'b1, val[i]});
    endtask

    task automatic push_gap();
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b110);
    endtask

    task automatic push_pkt(input logic [4:0] id, input logic dnr, input logic [4:0] len,
                            input logic [30:0] pay);
        exp_q.push_back(3'b011);
        push_bits({27'd0, len}, 5);
        exp_q.push_back({2'b01, dnr});
        push_bits({27'd0, id}, 5);
        push_bits({1'b0, pay}, int'(len));
        push_gap();
    endtask

    task automatic send(input logic mr, input logic [4:0] id, input logic dnr,
                        input logic [4:0] len, input logic [30:0] pay);
        int k;
        master_reset_i   = mr;
        nodeid_i         = id;
        data_not_reset_i = dnr;
        len_i            = len;
        payload_i        = pay;
        v_i              = 1'b1;
        k = 0;
        @(negedge clk);
        while (!ready_and_o && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("hs_ready", {31'd0, ready_and_o}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Pops n expected cycles (n < 0: whole queue); an idle entry drops v_i after its handshake edge.
    task automatic drain(input string tag, input int n);
        logic [2:0] e;
        int cnt;
        cnt = 0;
        while (exp_q.size() > 0 && (n < 0 || cnt < n)) begin
            e = exp_q.pop_front();
            @(negedge clk);
            chk({tag, "_en"},   {31'd0, tag_en_o},   {31'd0, e[1]});
            chk({tag, "_data"}, {31'd0, tag_data_o}, {31'd0, e[0]});
            chk({tag, "_done"}, {31'd0, done_o},     {31'd0, e[2]});
            rx_q.push_back(tag_data_o);
            if (!e[1]) begin
                @(posedge clk);
                #1 v_i = 1'b0;
            end
            cnt++;
        end
    endtask

    // Golden tag-master decode of the first packet in rx_q.
    task automatic decode(input string tag, input logic [4:0] id_exp, input logic [30:0] pay_exp);
        logic [4:0]  len, id;
        logic        dnr;
        logic [30:0] pay;
        len = '0; id = '0; pay = '0;
        for (int i = 0; i < 5; i++) len[i] = rx_q[1 + i];
        dnr = rx_q[6];
        for (int i = 0; i < 5; i++) id[i] = rx_q[7 + i];
        for (int i = 0; i < int'(len); i++) pay[i] = rx_q[12 + i];
        chk({tag, "_start"}, {31'd0, rx_q[0]}, 32'd1);
        chk({tag, "_dnr"},   {31'd0, dnr}, 32'd1);
        chk({tag, "_id"},    {27'd0, id}, {27'd0, id_exp});
        chk({tag, "_pay"},   {1'b0, pay}, {1'b0, pay_exp});
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        chk({tag, "_ready"}, {31'd0, ready_and_o}, 32'd1);
        chk({tag, "_en"},    {31'd0, tag_en_o}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        // 1: reset and idle
        #2;
        chk("rst_ready", {31'd0, ready_and_o}, 32'd0);
        chk("rst_en",    {31'd0, tag_en_o}, 32'd0);
        chk("rst_data",  {31'd0, tag_data_o}, 32'd0);
        chk("rst_busy",  {31'd0, busy_o}, 32'd0);
        chk("rst_done",  {31'd0, done_o}, 32'd0);
        chk("rst_err",   {31'd0, error_o}, 32'd0);
        @(posedge clk);
        #1 reset_i = 1'b0;
        repeat (10) begin
            idle_chk("idle");
            chk("idle_data", {31'd0, tag_data_o}, 32'd0);
        end

        // 2: master reset sequence
        send(1'b1, 5'd0, 1'b0, 5'd0, 31'd0);
        v_i = 1'b0;
        push_bits(32'hFFFF_FFFF, 32);
        push_bits(32'hFFFF_FFFF, 32);
        push_gap();
        drain("mrst", -1);
        idle_chk("mrst_after");

        // 3: single data packet, decoded by the golden model
        rx_q.delete();
        send(1'b0, 5'd5, 1'b1, 5'd8, 31'h0000_00A5);
        v_i = 1'b0;
        push_pkt(5'd5, 1'b1, 5'd8, 31'h0000_00A5);
        chk("pkt_len", exp_q.size(), 32'd22);
        drain("pkt", -1);
        decode("pkt", 5'd5, 31'h0000_00A5);
        idle_chk("pkt_after");

        // 4: back-to-back with v_i held high; high payload bits must stay unsent
        send(1'b0, 5'd17, 1'b1, 5'd3, 31'h7FFF_FFFA);
        nodeid_i  = 5'd9;
        len_i     = 5'd4;
        payload_i = 31'h7FFF_FFF9;
        push_pkt(5'd17, 1'b1, 5'd3, 31'h0000_0002);
        exp_q.push_back(3'b000);
        push_pkt(5'd9, 1'b1, 5'd4, 31'h0000_0009);
        drain("b2b", -1);
        idle_chk("b2b_after");

        // 5: asynchronous reset during PAY
        send(1'b0, 5'd7, 1'b1, 5'd20, 31'h7FFF_FFFF);
        v_i = 1'b0;
        push_pkt(5'd7, 1'b1, 5'd20, 31'h7FFF_FFFF);
        drain("arst", 15);
        #2;
        chk("arst_pre_en",   {31'd0, tag_en_o}, 32'd1);
        chk("arst_pre_data", {31'd0, tag_data_o}, 32'd1);
        reset_i = 1'b1;
        #1;
        chk("arst_en",    {31'd0, tag_en_o}, 32'd0);
        chk("arst_data",  {31'd0, tag_data_o}, 32'd0);
        chk("arst_ready", {31'd0, ready_and_o}, 32'd0);
        chk("arst_busy",  {31'd0, busy_o}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 reset_i = 1'b0;
        rx_q.delete();
        send(1'b0, 5'd3, 1'b1, 5'd6, 31'h0000_002D);
        v_i = 1'b0;
        push_pkt(5'd3, 1'b1, 5'd6, 31'h0000_002D);
        drain("post", -1);
        decode("post", 5'd3, 31'h0000_002D);

        // 6: zero-length data packet
`ifdef BSG_TAG_SERIAL_TX_LEN_CHECK_EN
        send(1'b0, 5'd9, 1'b1, 5'd0, 31'h7FFF_FFFF);
        v_i = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("rej_en",   {31'd0, tag_en_o}, 32'd0);
            chk("rej_done", {31'd0, done_o}, 32'd0);
            chk("rej_err",  {31'd0, error_o}, 32'd1);
        end
        send(1'b0, 5'd2, 1'b1, 5'd2, 31'h0000_0001);
        v_i = 1'b0;
        push_pkt(5'd2, 1'b1, 5'd2, 31'h0000_0001);
        drain("rej_next", -1);
        chk("rej_err_sticky", {31'd0, error_o}, 32'd1);
`else
        send(1'b0, 5'd9, 1'b1, 5'd0, 31'h7FFF_FFFF);
        v_i = 1'b0;
        push_pkt(5'd9, 1'b1, 5'd0, 31'h0);
        chk("zl_len", exp_q.size(), 32'd14);
        drain("zl", -1);
        idle_chk("zl_after");
        chk("zl_err", {31'd0, error_o}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
